// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line-follow steering controller.
package line_follow_pkg;

    localparam logic [2:0] MODE_STRAIGHT  = 3'b000;
    localparam logic [2:0] MODE_BIG_RIGHT = 3'b001;
    localparam logic [2:0] MODE_BIG_LEFT  = 3'b010;
    localparam logic [2:0] MODE_RIGHT     = 3'b011;
    localparam logic [2:0] MODE_LEFT      = 3'b100;
    localparam logic [2:0] MODE_STOP      = 3'b101;

    typedef enum logic [1:0] {TRACK, SEARCH, HALT} state_t;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

    typedef struct packed {
        logic [2:0] mode;
        dir_t       dir;
    } steer_t;

    function automatic logic [2:0] big_turn(input dir_t d);
        return (d == DIR_RIGHT) ? MODE_BIG_RIGHT : MODE_BIG_LEFT;
    endfunction

    // Patterns 101 and 000 keep the current mode and direction memory.
    function automatic steer_t track_map(input logic [2:0] pat, input logic [2:0] cur_mode,
                                         input dir_t cur_dir);
        steer_t s;
        s.mode = cur_mode;
        s.dir  = cur_dir;
        case (pat)
            3'b010, 3'b111: s.mode = MODE_STRAIGHT;
            3'b110: begin s.mode = MODE_LEFT;      s.dir = DIR_LEFT;  end
            3'b100: begin s.mode = MODE_BIG_LEFT;  s.dir = DIR_LEFT;  end
            3'b011: begin s.mode = MODE_RIGHT;     s.dir = DIR_RIGHT; end
            3'b001: begin s.mode = MODE_BIG_RIGHT; s.dir = DIR_RIGHT; end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/line_follow_ctrl_if.sv
// Sensor inputs and steering outputs of the line-follow controller.
interface line_follow_ctrl_if;
    logic       left_signal;
    logic       mid_signal;
    logic       right_signal;
    logic [2:0] mode;
    logic       lost;
    logic       mode_chg;

    modport master (output left_signal, mid_signal, right_signal,
                    input  mode, lost, mode_chg);
    modport slave  (input  left_signal, mid_signal, right_signal,
                    output mode, lost, mode_chg);
endinterface

// File: rtl/lf_sensor_filter.sv
// Two-flop synchroniser, sample tick and consecutive-sample filter for the
// {left, mid, right} IR sensor vector.
module lf_sensor_filter #(
    parameter int SAMPLE_DIV = 100000,
    parameter int FILT_LEN   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] raw,
    output logic [2:0] acc,
    output logic       acc_valid
);
    localparam int CW = $clog2(SAMPLE_DIV);

    logic [2:0]    sync1, sync2, cand, cand_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    fcnt, fcnt_nxt;
    logic          tick;

    assign tick = (cnt == CW'(SAMPLE_DIV - 1));

    always_comb begin
        cand_nxt = cand;
        fcnt_nxt = fcnt;
        if (sync2 == cand) begin
            if (fcnt != 4'(FILT_LEN))
                fcnt_nxt = fcnt + 4'd1;
        end else begin
            cand_nxt = sync2;
            fcnt_nxt = 4'd1;
        end
    end

    // While saturated, every tick reloads acc and re-raises acc_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            cnt       <= '0;
            cand      <= '0;
            fcnt      <= '0;
            acc       <= '0;
            acc_valid <= 1'b0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            cnt       <= tick ? '0 : cnt + CW'(1);
            acc_valid <= 1'b0;
            if (tick) begin
                cand <= cand_nxt;
                fcnt <= fcnt_nxt;
                if (fcnt_nxt == 4'(FILT_LEN)) begin
                    acc       <= cand_nxt;
                    acc_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/line_follow_ctrl.sv
// Track/search/halt steering FSM fed by the filtered IR sensor vector.
// Optional macro JUNCTION_STOP_EN: a 111 junction in TRACK halts the car.
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int SAMPLE_DIV   = 100000,
    parameter int FILT_LEN     = 4,
    parameter int LOST_TIMEOUT = 500
) (
    input logic               clk,
    input logic               rst,
    line_follow_ctrl_if.slave bus
);
    localparam int LCW = $clog2(LOST_TIMEOUT + 1);

    logic [2:0]     acc, mode_q, mode_n;
    logic           acc_valid, lost_q, lost_n, chg_q, go_track;
    state_t         state, state_n;
    dir_t           dir_q, dir_n;
    logic [LCW-1:0] lcnt, lcnt_n;
    steer_t         steer;

    lf_sensor_filter #(.SAMPLE_DIV(SAMPLE_DIV), .FILT_LEN(FILT_LEN)) u_filter (
        .clk       (clk),
        .rst       (rst),
        .raw       ({bus.left_signal, bus.mid_signal, bus.right_signal}),
        .acc       (acc),
        .acc_valid (acc_valid)
    );

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        lost_n   = lost_q;
        dir_n    = dir_q;
        lcnt_n   = lcnt;
        go_track = 1'b0;
        steer    = track_map(acc, mode_q, dir_q);
        if (acc_valid) begin
            unique case (state)
                TRACK: begin
                    if (acc == 3'b000) begin
                        state_n = SEARCH;
                        lost_n  = 1'b1;
                        lcnt_n  = '0;
                        mode_n  = big_turn(dir_q);
                    end
`ifdef JUNCTION_STOP_EN
                    else if (acc == 3'b111) begin
                        state_n = HALT;
                        mode_n  = MODE_STOP;
                        lost_n  = 1'b0;
                    end
`endif
                    else
                        go_track = 1'b1;
                end
                SEARCH: begin
                    if (acc == 3'b000) begin
                        if (lcnt == LCW'(LOST_TIMEOUT - 1)) begin
                            state_n = HALT;
                            mode_n  = MODE_STOP;
                        end else
                            lcnt_n = lcnt + LCW'(1);
                    end else
                        go_track = 1'b1;
                end
`ifdef JUNCTION_STOP_EN
                HALT: if (acc != 3'b000 && acc != 3'b111) go_track = 1'b1;
`else
                HALT: if (acc != 3'b000) go_track = 1'b1;
`endif
                default: state_n = HALT;
            endcase
            // Leaving SEARCH/HALT applies the TRACK mapping in the same evaluation.
            if (go_track) begin
                state_n = TRACK;
                lost_n  = 1'b0;
                mode_n  = steer.mode;
                dir_n   = steer.dir;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= HALT;
            mode_q <= MODE_STOP;
            lost_q <= 1'b0;
            dir_q  <= DIR_LEFT;
            lcnt   <= '0;
            chg_q  <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            lost_q <= lost_n;
            dir_q  <= dir_n;
            lcnt   <= lcnt_n;
            chg_q  <= (mode_n != mode_q);
        end
    end

    assign bus.mode     = mode_q;
    assign bus.lost     = lost_q;
    assign bus.mode_chg = chg_q;
endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl with SAMPLE_DIV=4, FILT_LEN=3, LOST_TIMEOUT=5.
module tb_line_follow_ctrl;
    import line_follow_pkg::*;

    typedef struct {
        logic [2:0] pat;
        logic       fixed;
        logic [2:0] mode;
        logic       lost;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   chg_cnt = 0;
    int   chg_base;
    int   n;
    logic lost_bad;
    vec_t tbl[9];

    always #5 clk = ~clk;

    line_follow_ctrl_if bus();

    line_follow_ctrl #(.SAMPLE_DIV(4), .FILT_LEN(3), .LOST_TIMEOUT(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.mode_chg === 1'b1) chg_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] p);
        {bus.left_signal, bus.mid_signal, bus.right_signal} = p;
    endtask

    task automatic wait_mode(input logic [2:0] m, input logic l, input int bound, output int cyc);
        cyc = 0;
        while (!(bus.mode === m && bus.lost === l) && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Poll for mode 000 after reset release, flagging any lost assertion.
    task automatic wait_straight(output int cyc, output logic lb);
        cyc = 1;
        lb  = 1'b0;
        @(negedge clk);
        while (bus.mode !== MODE_STRAIGHT && cyc < 16) begin
            @(negedge clk);
            cyc++;
            if (bus.lost !== 1'b0) lb = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'b011, 1'b0, MODE_RIGHT,     1'b0};
        tbl[1] = '{3'b101, 1'b1, MODE_RIGHT,     1'b0};
        tbl[2] = '{3'b001, 1'b0, MODE_BIG_RIGHT, 1'b0};
        tbl[3] = '{3'b100, 1'b0, MODE_BIG_LEFT,  1'b0};
`ifdef JUNCTION_STOP_EN
        tbl[4] = '{3'b111, 1'b1, MODE_STOP,      1'b0};
`else
        tbl[4] = '{3'b111, 1'b1, MODE_STRAIGHT,  1'b0};
`endif
        tbl[5] = '{3'b011, 1'b0, MODE_RIGHT,     1'b0};
        tbl[6] = '{3'b000, 1'b0, MODE_BIG_RIGHT, 1'b1};
        tbl[7] = '{3'b110, 1'b0, MODE_LEFT,      1'b0};
        tbl[8] = '{3'b010, 1'b0, MODE_STRAIGHT,  1'b0};

        // Reset values, then 010 must be accepted within 16 cycles with one mode_chg.
        drive(3'b010);
        #12;
        check("reset_mode", bus.mode, MODE_STOP);
        check("reset_lost", bus.lost, 0);
        check("reset_chg", bus.mode_chg, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_straight(n, lost_bad);
        check("startup_mode", bus.mode, MODE_STRAIGHT);
        check("startup_lost_quiet", lost_bad, 0);
        repeat (8) @(negedge clk);
        check("startup_chg_pulses", chg_cnt, 1);

        // One-tick glitch to 000 must be filtered out.
        chg_base = chg_cnt;
        drive(3'b000);
        repeat (4) @(negedge clk);
        drive(3'b010);
        repeat (24) @(negedge clk);
        check("glitch_mode", bus.mode, MODE_STRAIGHT);
        check("glitch_chg", chg_cnt - chg_base, 0);

        // Line loss after a left turn: search big left, then halt after 5 more 000 samples.
        drive(3'b110);
        wait_mode(MODE_LEFT, 1'b0, 20, n);
        check("left_mode", bus.mode, MODE_LEFT);
        drive(3'b000);
        wait_mode(MODE_BIG_LEFT, 1'b1, 20, n);
        check("search_mode", bus.mode, MODE_BIG_LEFT);
        check("search_lost", bus.lost, 1);
        n = 0;
        while (bus.mode !== MODE_STOP && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, 20);
        check("halt_mode", bus.mode, MODE_STOP);
        check("halt_lost", bus.lost, 1);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].pat);
            if (tbl[i].fixed)
                repeat (24) @(negedge clk);
            else
                wait_mode(tbl[i].mode, tbl[i].lost, 20, n);
            check($sformatf("vec%0d_mode", i), bus.mode, tbl[i].mode);
            check($sformatf("vec%0d_lost", i), bus.lost, tbl[i].lost);
        end

        // Asynchronous reset while searching clears outputs before any clock edge.
        drive(3'b000);
        wait_mode(MODE_BIG_LEFT, 1'b1, 20, n);
        check("pre_reset_lost", bus.lost, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_mode", bus.mode, MODE_STOP);
        check("async_reset_lost", bus.lost, 0);
        drive(3'b010);
        @(negedge clk);
        rst = 1'b1;
        wait_straight(n, lost_bad);
        check("rerun_mode", bus.mode, MODE_STRAIGHT);
        check("rerun_lost_quiet", lost_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
